// File: rtl/syncnt_pkg.sv
// Shared types for the sync_counter_n family: terminal-behaviour mode encoding.
package syncnt_pkg;

  typedef enum logic [1:0] {
    CM_WRAP    = 2'b00,
    CM_RELOAD  = 2'b01,
    CM_ONESHOT = 2'b10,
    CM_RSVD    = 2'b11
  } cnt_mode_t;

endpackage

// File: rtl/syncnt_term.sv
// Terminal-value detector: all ones when counting up, zero when counting down.
module syncnt_term #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             UD,
  output logic             at_term
);

  logic w_all_ones;
  logic w_all_zero;

  assign w_all_ones = &Q;
  assign w_all_zero = ~(|Q);
  assign at_term    = UD ? w_all_ones : w_all_zero;

endmodule

// File: rtl/sync_counter_n.sv
// WIDTH-bit load/count/clear counter with up/down, wrap, auto-reload and one-shot
// terminal modes, plus a combinational carry chain for cascading.
module sync_counter_n
  import syncnt_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_RLD = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LDL,
  input  logic             RLDL,
  input  logic [WIDTH-1:0] D,
  input  logic             CI,
  input  logic             UD,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             CO,
  output logic             TCP,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rld;
  logic             r_done;
  logic             r_tcp;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_done_nxt;
  logic             w_at_term;
  logic             w_cnt_en;
  logic             w_term_evt;
  cnt_mode_t        w_mode;

  assign w_mode = cnt_mode_t'(MODE);

  syncnt_term #(
    .WIDTH (WIDTH)
  ) u_term (
    .Q       (r_q),
    .UD      (UD),
    .at_term (w_at_term)
  );

  // Counting is suppressed by a load in the same cycle and by an expired one-shot.
  assign w_cnt_en   = CI & LDL & ~r_done;
  assign w_term_evt = w_cnt_en & w_at_term;

  always_comb begin
    w_q_nxt    = r_q;
    w_done_nxt = r_done;
    if (!LDL) begin
      w_q_nxt    = D;
      w_done_nxt = 1'b0;
    end else if (w_cnt_en) begin
      if (!w_at_term) begin
        w_q_nxt = UD ? (r_q + LP_ONE) : (r_q - LP_ONE);
      end else begin
        unique case (w_mode)
          CM_RELOAD:  w_q_nxt    = r_rld;
          CM_ONESHOT: w_done_nxt = 1'b1;
          CM_WRAP,
          CM_RSVD:    w_q_nxt    = UD ? '0 : '1;
          default:    w_q_nxt    = r_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_q    <= '0;
      r_rld  <= RST_RLD;
      r_done <= 1'b0;
      r_tcp  <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_done <= w_done_nxt;
      r_tcp  <= w_term_evt;
      // Reload write lands after this edge, so a same-cycle terminal event uses the old value.
      if (!RLDL) begin
        r_rld <= D;
      end
    end
  end

  assign Q    = r_q;
  assign QB   = ~r_q;
  assign CO   = CI & w_at_term & ~r_done;
  assign TCP  = r_tcp;
  assign DONE = r_done;

endmodule
